// File: rtl/fp_result_fifo.sv
// fp_result_fifo: first-word-fall-through buffer for adder sums with sticky overflow flag.
// Define FP_RESULT_FIFO_NAN_DETECT_EN to tag NaN entries and drive nanOut for the head word.
module fp_result_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clkIn,
    input  logic                       rstIn,
    input  logic [DATA_WIDTH-1:0]      dataIn,
    input  logic                       validIn,
    output logic [DATA_WIDTH-1:0]      dataOut,
    output logic                       validOut,
    input  logic                       readyIn,
    output logic [$clog2(DEPTH):0]     countOut,
    output logic                       overflowOut,
    output logic                       nanOut
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;

    always_comb begin
        validOut    = r_count != '0;
        w_full      = r_count == FULL;
        w_pop       = validOut && readyIn;
        w_push      = validIn && (!w_full || w_pop);
        dataOut     = validOut ? r_mem[r_rd_ptr] : '0;
        countOut    = r_count;
        overflowOut = r_overflow;
    end

    // Storage is deliberately left out of reset; validOut masks stale contents.
    always_ff @(posedge clkIn) begin
        if (!rstIn && w_push) r_mem[r_wr_ptr] <= dataIn;
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (validIn && !w_push) r_overflow <= 1'b1;
        end
    end

`ifdef FP_RESULT_FIFO_NAN_DETECT_EN
    logic r_tag [DEPTH];

    always_ff @(posedge clkIn) begin
        if (!rstIn && w_push) r_tag[r_wr_ptr] <= (&dataIn[30:23]) && (|dataIn[22:0]);
    end

    always_comb nanOut = validOut && r_tag[r_rd_ptr];
`else
    always_comb nanOut = 1'b0;
`endif
endmodule

// File: tb/tb_fp_result_fifo.sv
// tb_fp_result_fifo: directed and randomized checks of fp_result_fifo against a queue model.
module tb_fp_result_fifo;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clkIn = 1'b0;
    logic          rstIn = 1'b0;
    logic          validIn = 1'b0;
    logic          readyIn = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic [DW-1:0] dataOut;
    logic          validOut;
    logic [CW-1:0] countOut;
    logic          overflowOut;
    logic          nanOut;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q[$];
    bit m_ovf = 1'b0;

    fp_result_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .validIn(validIn),
        .dataOut(dataOut), .validOut(validOut), .readyIn(readyIn),
        .countOut(countOut), .overflowOut(overflowOut), .nanOut(nanOut)
    );

    always #5 clkIn = ~clkIn;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    function automatic bit is_nan(input logic [31:0] w);
        return w[30:23] == 8'hFF && w[22:0] != 23'd0;
    endfunction

    function automatic logic [DW-1:0] exp_head();
        return q.size() != 0 ? q[0] : '0;
    endfunction

    function automatic bit exp_nan();
`ifdef FP_RESULT_FIFO_NAN_DETECT_EN
        return q.size() != 0 && is_nan(q[0]);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: drive inputs, advance the model at the edge, return at the falling edge.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r, input bit rs);
        bit pop;
        bit ok;
        validIn = v; dataIn = d; readyIn = r; rstIn = rs;
        @(posedge clkIn);
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            pop = q.size() != 0 && r;
            ok  = q.size() < DEPTH || pop;
            if (pop) void'(q.pop_front());
            if (v && ok) q.push_back(d);
            if (v && !ok) m_ovf = 1'b1;
        end
        @(negedge clkIn);
        validIn = 1'b0; readyIn = 1'b0; rstIn = 1'b0; dataIn = '0;
    endtask

    task automatic test_reset();
        cyc(0, '0, 0, 1);
        checks++;
        if ({validOut, dataOut, countOut, overflowOut, nanOut} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d o=%b n=%b, expected all zero",
                     validOut, dataOut, countOut, overflowOut, nanOut);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 1, 0);
            checks++;
            if (countOut !== '0 || validOut !== 1'b0 || dataOut !== '0) begin
                errors++;
                $display("FAIL idle_ready: got c=%0d v=%b d=%h, expected c=0 v=0 d=0", countOut, validOut, dataOut);
            end
        end
    endtask

    task automatic test_burst();
        logic [DW-1:0] w [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
        for (int i = 0; i < 3; i++) cyc(1, w[i], 0, 0);
        checks++;
        if (countOut !== CW'(3) || dataOut !== 32'h3F800000) begin
            errors++;
            $display("FAIL burst_fill: got c=%0d d=%h, expected c=3 d=3f800000", countOut, dataOut);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (validOut !== 1'b1 || dataOut !== w[i]) begin
                errors++;
                $display("FAIL burst_pop%0d: got v=%b d=%h, expected v=1 d=%h", i, validOut, dataOut, w[i]);
            end
            cyc(0, '0, 1, 0);
        end
        checks++;
        if (validOut !== 1'b0 || countOut !== '0) begin
            errors++;
            $display("FAIL burst_empty: got v=%b c=%0d, expected v=0 c=0", validOut, countOut);
        end
    endtask

    task automatic test_stream();
        cyc(1, 32'h1000_0000, 1, 0);
        for (int i = 1; i <= 40; i++) begin
            cyc(1, 32'h1000_0000 + i, 1, 0);
            checks++;
            if (dataOut !== 32'h1000_0000 + i || countOut !== CW'(1) || overflowOut !== 1'b0) begin
                errors++;
                $display("FAIL stream%0d: got d=%h c=%0d o=%b, expected d=%h c=1 o=0",
                         i, dataOut, countOut, overflowOut, 32'h1000_0000 + i);
            end
        end
        cyc(0, '0, 1, 0);
        checks++;
        if (validOut !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: got v=%b, expected v=0", validOut);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] w [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = $urandom;
            cyc(1, w[i], 0, 0);
        end
        cyc(1, 32'hDEADBEEF, 0, 0);
        checks++;
        if (overflowOut !== 1'b1 || countOut !== CW'(DEPTH) || dataOut !== w[0]) begin
            errors++;
            $display("FAIL ovf_drop: got o=%b c=%0d d=%h, expected o=1 c=16 d=%h", overflowOut, countOut, dataOut, w[0]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (dataOut !== w[i] || overflowOut !== 1'b1) begin
                errors++;
                $display("FAIL ovf_drain%0d: got d=%h o=%b, expected d=%h o=1", i, dataOut, overflowOut, w[i]);
            end
            cyc(0, '0, 1, 0);
        end
        checks++;
        if (validOut !== 1'b0 || overflowOut !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got v=%b o=%b, expected v=0 o=1", validOut, overflowOut);
        end
        cyc(0, '0, 0, 1);
        checks++;
        if (overflowOut !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got o=%b, expected o=0", overflowOut);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] w [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = $urandom;
            cyc(1, w[i], 0, 0);
        end
        cyc(1, 32'h41200000, 1, 0);
        checks++;
        if (countOut !== CW'(DEPTH) || overflowOut !== 1'b0 || dataOut !== w[1]) begin
            errors++;
            $display("FAIL full_pp: got c=%0d o=%b d=%h, expected c=16 o=0 d=%h", countOut, overflowOut, dataOut, w[1]);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (dataOut !== (i == DEPTH ? 32'h41200000 : w[i])) begin
                errors++;
                $display("FAIL full_pp_drain%0d: got d=%h, expected d=%h", i, dataOut,
                         i == DEPTH ? 32'h41200000 : w[i]);
            end
            cyc(0, '0, 1, 0);
        end
    endtask

    task automatic test_nan();
        logic [DW-1:0] w [3] = '{32'h7FC00000, 32'h7F800000, 32'h00000000};
        bit en;
`ifdef FP_RESULT_FIFO_NAN_DETECT_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        for (int i = 0; i < 3; i++) cyc(1, w[i], 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (nanOut !== (en && i == 0) || dataOut !== w[i]) begin
                errors++;
                $display("FAIL nan%0d: got n=%b d=%h, expected n=%b d=%h", i, nanOut, dataOut, en && i == 0, w[i]);
            end
            cyc(0, '0, 1, 0);
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 5; i++) cyc(1, 32'hA000_0000 + i, 0, 0);
        checks++;
        if (countOut !== CW'(5)) begin
            errors++;
            $display("FAIL mid_fill: got c=%0d, expected c=5", countOut);
        end
        cyc(1, 32'hBADBAD00, 1, 1);
        checks++;
        if (countOut !== '0 || validOut !== 1'b0 || dataOut !== '0) begin
            errors++;
            $display("FAIL mid_reset: got c=%0d v=%b d=%h, expected c=0 v=0 d=0", countOut, validOut, dataOut);
        end
        cyc(1, 32'h12345678, 0, 0);
        checks++;
        if (countOut !== CW'(1) || dataOut !== 32'h12345678) begin
            errors++;
            $display("FAIL mid_push: got c=%0d d=%h, expected c=1 d=12345678", countOut, dataOut);
        end
        cyc(0, '0, 1, 0);
        checks++;
        if (validOut !== 1'b0 || countOut !== '0) begin
            errors++;
            $display("FAIL mid_pop: got v=%b c=%0d, expected v=0 c=0", validOut, countOut);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        int rp;
        for (int i = 0; i < 2000; i++) begin
            rp = (i / 250) % 2 == 0 ? 30 : 80;
            d = ($urandom_range(0, 7) == 0) ? {1'b0, 8'hFF, 23'($urandom_range(0, 3))} : $urandom;
            cyc($urandom_range(0, 99) < 60, d, $urandom_range(0, 99) < rp, $urandom_range(0, 499) == 0);
            checks++;
            if (validOut !== (q.size() != 0) || dataOut !== exp_head() || countOut !== CW'(q.size())
                || overflowOut !== m_ovf || nanOut !== exp_nan()) begin
                errors++;
                $display("FAIL random%0d: got v=%b d=%h c=%0d o=%b n=%b, expected v=%b d=%h c=%0d o=%b n=%b",
                         i, validOut, dataOut, countOut, overflowOut, nanOut,
                         q.size() != 0, exp_head(), q.size(), m_ovf, exp_nan());
            end
        end
    endtask

    initial begin
        @(negedge clkIn);
        test_reset();
        test_burst();
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_nan();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_result_fifo.md
# fp_result_fifo

Result buffer directly downstream of `floating_point_add`. The adder has no back-pressure input and emits one 32-bit IEEE-754 sum per `validOut` pulse, so this block captures every sum into a first-word-fall-through FIFO. It presents the sums to the consumer (result writer or file checker) with a ready/valid handshake. It reports occupancy and flags any sum lost to overflow.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `DATA_WIDTH`, 32, word width (IEEE-754 single)

Ports:
- `clkIn` input 1: single clock; all logic on rising edge
- `rstIn` input 1: reset; synchronous, active-high
- `dataIn` input DATA_WIDTH: sum from adder `dataOut`
- `validIn` input 1: sum valid, from adder `validOut`; no ready is returned
- `dataOut` output DATA_WIDTH: head-of-FIFO word
- `validOut` output 1: FIFO non-empty, `dataOut` valid
- `readyIn` input 1: consumer accepts head word
- `countOut` output $clog2(DEPTH)+1: entries held
- `overflowOut` output 1: sticky; a `validIn` word was dropped
- `nanOut` output 1: head word is NaN (see Configuration)

## Operation
- Storage: DEPTH-entry register array, write pointer, read pointer, occupancy counter. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: occurs when `validIn` is high and `push_ok` is true.
  - `push_ok` = (count < DEPTH) OR pop in the same cycle.
  - On push: word is written at the write pointer, then the write pointer increments.
- Pop: occurs when `validOut` and `readyIn` are both high. The read pointer increments. `readyIn` while empty is ignored.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither. Count never exceeds DEPTH and never drops below 0.
- Full with simultaneous push and pop: the new word is accepted, the head is consumed, and count stays at DEPTH.
- Full, `validIn` high, no pop: the word is discarded, and `overflowOut` is set on the next edge.
  - `overflowOut` stays set until `rstIn`.
  - Stored contents and pointers are unaffected.
- Empty with `validIn` high and `readyIn` high: no pop that cycle, because `validOut` is low. The word is stored and appears on the next cycle.
- `validOut` = (count != 0).
- `dataOut` = array[read pointer] when `validOut`, else all-zero.
- Data is stored bit-exact; there is no arithmetic on the payload.

## Timing
- Reset, when `rstIn` is high at an edge:
  - pointers and count become 0
  - `validOut`=0, `dataOut`=0, `countOut`=0, `overflowOut`=0, `nanOut`=0
  - the array is not cleared
- A reset asserted mid-stream discards all stored words. Inputs in the reset cycle are ignored.
- Latency: a word pushed at edge N is visible on `dataOut` with `validOut`=1 after edge N, i.e. during cycle N+1. Fall-through latency is 1 cycle.
- The head changes only after a pop edge. The next word, if any, is valid in the following cycle. Sustained throughput is 1 word/cycle.
- `countOut` and `overflowOut` are registered and update 1 cycle after the triggering edge inputs.
- `dataOut`, `validOut` and `nanOut` are decoded combinationally from registered state only; there is no path from `readyIn` or `validIn`.
- Order is strictly FIFO, with no reordering across wrap.

## Configuration
- Macro: `FP_RESULT_FIFO_NAN_DETECT_EN`.
- Defined:
  - On push, a per-entry tag bit stores whether `dataIn` is NaN (exponent [30:23] all ones and mantissa [22:0] non-zero).
  - `nanOut` = tag[read pointer] when `validOut`, else 0.
  - Infinities (mantissa 0) are not flagged.
- Undefined: no tag storage, and `nanOut` is tied to 0.

## Test plan
- Reset then idle:
  - all outputs are 0
  - pulsing `readyIn` for 5 cycles changes nothing and `countOut` stays 0
- Push 0x3F800000, 0x40000000, 0x40400000 on consecutive cycles with `readyIn`=0:
  - `countOut`=3 and the head is 0x3F800000
  - then with `readyIn`=1, the words are popped in order on 3 consecutive cycles and `validOut` drops after the third
- Streaming, `validIn`=`readyIn`=1 for 40 cycles with incrementing words:
  - every word emerges 1 cycle later
  - `countOut` stays at 1
  - correct wrap past DEPTH=16
  - `overflowOut`=0
- Fill 16 words, then push 0xDEADBEEF with `readyIn`=0:
  - the word is dropped and `overflowOut`=1, `countOut`=16
  - draining returns the original 16 words
  - `overflowOut` stays 1 until reset
- Full, push 0x41200000 while popping in the same cycle:
  - the word is accepted and `countOut` stays 16
  - it emerges as the 16th word after the pop
- With the macro defined, push 0x7FC00000, 0x7F800000, 0x00000000:
  - `nanOut` is 1, 0, 0 as each reaches the head
  - with the macro undefined, `nanOut` is always 0
- Assert `rstIn` with 5 entries held:
  - next cycle `countOut`=0 and `validOut`=0
  - a subsequent push and pop works from pointer 0
